display_scan_controller: RTL
============================

// Module: display_scan_controller
// PURPOSE
//   Scan engine for the 8-digit seven-segment display.
//   - Generates the 3-bit digit index that drives the downstream nibble multiplexer, plus the active-low anode enables.
//   - Captures a tear-free 32-bit frame of the value to be shown.
//   - Inserts an all-off blanking gap before each digit to suppress ghosting.
// PARAMETERS
//   CLK_FREQ_HZ   100_000_000  input clock frequency
//   SCAN_RATE_HZ  1_000        per-digit dwell rate; DIV = CLK_FREQ_HZ/SCAN_RATE_HZ clocks per digit
//   BLANK_CYCLES  16           clocks at start of each dwell with all anodes off; elaboration error unless 0 < BLANK_CYCLES < DIV
// PORTS
//   clk         in   1   system clock, all logic on rising edge
//   reset_n     in   1   asynchronous, active-low reset
//   hex_in      in   32  value to display, 8 nibbles, digit i = hex_in[4i+3:4i]
//   digit_en    in   8   per-digit enable mask, 1 = digit may light
//   hex_frame   out  32  frame snapshot fed to the nibble mux
//   counter     out  3   current digit index fed to the nibble mux
//   anodes      out  8   active-low anode drive, one-hot-low or all 1
//   frame_tick  out  1   1-cycle pulse when a new frame is captured
// BEHAVIOUR
//   Reset values (asynchronous, immediate, including mid-dwell):
//     state=S_BLANK, prescaler=0, counter=0, hex_frame=0, anodes=8'hFF, frame_tick=0.
//   FSM, two states; prescaler counts 0..DIV-1 within each digit dwell:
//     S_BLANK: anodes=8'hFF. When prescaler==BLANK_CYCLES-1, go to S_SHOW.
//     S_SHOW : anodes[counter]=~lit, all other bits 1. When prescaler==DIV-1:
//              prescaler<=0, counter<=counter+1 (7 wraps to 0), go to S_BLANK.
//   lit = digit_en[counter], sampled every clock while in S_SHOW; a mask change takes effect on the next clock.
//   Frame capture: on the edge where counter wraps 7->0, hex_frame<=hex_in and frame_tick=1 for exactly that cycle.
//     hex_frame is otherwise stable, so all 8 digits of a frame come from one snapshot.
//     The first frame after reset therefore displays 0.
//   anodes, counter, hex_frame and frame_tick are all registered and change on the same edge.
//     They are never combinationally derived from inputs.
//   Dwell length is exactly DIV clocks: BLANK_CYCLES clocks blank, then DIV-BLANK_CYCLES clocks lit.
//     Full frame = 8*DIV clocks.
//   digit_en=8'h00: the scan continues (counter and frame_tick unchanged); anodes stay 8'hFF.
// CONFIGURATION
//   LEADING_ZERO_SUPPRESS_EN defined:
//     - In S_SHOW, digit i>0 is additionally unlit when hex_frame[31:4i]==0.
//     - Digit 0 is never suppressed.
//     - Suppression uses hex_frame, never hex_in.
//   Not defined: lit depends only on digit_en.
// STRUCTURE
//   Package display_pkg holds:
//     - NUM_DIGITS=8
//     - typedef logic [2:0] digit_idx_t
//     - typedef enum logic {S_BLANK, S_SHOW} scan_state_t
//     - localparam ANODES_OFF=8'hFF
//   One sub-module, scan_prescaler: DIV-modulo counter with outputs blank_done and dwell_done.
//     It is cleared by the same async reset_n.
//   The FSM, the digit counter, frame capture and anode decode live in the top module.
// TESTING (bench parameters CLK_FREQ_HZ=1000, SCAN_RATE_HZ=100 -> DIV=10, BLANK_CYCLES=2)
//   1. Reset then run, digit_en=FF -> anodes=FF for cycles 0-1.
//      Then FE for cycles 2-9, counter=1 at cycle 10; counter reaches 7 then wraps to 0 at cycle 80.
//   2. hex_in=32'h1234_5678, then change hex_in mid-frame -> frame_tick pulses once at cycle 80 only.
//      hex_frame=1234_5678 captured then; the mid-frame change appears only at the next wrap.
//   3. digit_en=8'b0000_0101 -> only FE (counter 0) and FB (counter 2) appear; all other dwells stay FF.
//   4. Assert reset_n low at cycle 45 (mid-dwell, digit 4) -> outputs reset immediately, without waiting for a clock.
//      After release, the sequence restarts exactly as in test 1.
//   5. LEADING_ZERO_SUPPRESS_EN, hex_frame=32'h0000_00A0 -> only digits 0 and 1 light.
//      hex_frame=0 -> only digit 0 lights.
//   6. Over 1000 cycles, check anodes has at most one 0 bit every cycle, and it is never 0 while in S_BLANK.

Source files
------------

// File: rtl/display_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// display_pkg: shared types and constants for the 8-digit scan engine
// Rev 1.0
// ------------------------------------------------------------------
package display_pkg;

   localparam int NUM_DIGITS = 8;

   typedef logic [2:0] digit_idx_t;

   typedef enum logic {S_BLANK, S_SHOW} scan_state_t;

   localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 8'hFF;

   // True when every nibble at or above position idx is zero
   function automatic logic upper_nibbles_zero(input logic [31:0] frame, input digit_idx_t idx);
      logic [31:0] mask;
      mask = 32'hFFFF_FFFF << {idx, 2'b00};
      return (frame & mask) == 32'h0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/scan_prescaler.sv
`default_nettype none
// ------------------------------------------------------------------
// scan_prescaler: DIV-modulo dwell counter with blank/dwell strobes
// Rev 1.0
// ------------------------------------------------------------------
module scan_prescaler #(
   parameter int DIV          = 10,
   parameter int BLANK_CYCLES = 2
) (
   input  logic clk,
   input  logic reset_n,
   output logic o_blank_done,
   output logic o_dwell_done
);

   localparam int c_width = (DIV > 1) ? $clog2(DIV) : 1;

   logic [c_width-1:0] r_count;

   assign o_blank_done = (r_count == c_width'(BLANK_CYCLES - 1));
   assign o_dwell_done = (r_count == c_width'(DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (o_dwell_done) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + c_width'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/display_scan_controller.sv
`default_nettype none
// ------------------------------------------------------------------
// display_scan_controller: 8-digit 7-seg scan with blanking and frame
// snapshot. Optional LEADING_ZERO_SUPPRESS_EN blanks leading zeros.
// Rev 1.0
// ------------------------------------------------------------------
module display_scan_controller
   import display_pkg::*;
#(
   parameter int CLK_FREQ_HZ  = 100_000_000,
   parameter int SCAN_RATE_HZ = 1_000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [31:0]           hex_in,
   input  logic [NUM_DIGITS-1:0] digit_en,
   output logic [31:0]           hex_frame,
   output logic [2:0]            counter,
   output logic [NUM_DIGITS-1:0] anodes,
   output logic                  frame_tick
);

   localparam int c_div = CLK_FREQ_HZ / SCAN_RATE_HZ;

   generate
      if (BLANK_CYCLES <= 0 || BLANK_CYCLES >= c_div) begin : g_bad_blank
         $error("BLANK_CYCLES must satisfy 0 < BLANK_CYCLES < CLK_FREQ_HZ/SCAN_RATE_HZ");
      end
   endgenerate

   scan_state_t           r_state;
   digit_idx_t            r_counter;
   logic [31:0]           r_hex_frame;
   logic [NUM_DIGITS-1:0] r_anodes;
   logic                  r_frame_tick;

   logic                  w_blank_done;
   logic                  w_dwell_done;
   logic                  w_lit;
   logic [NUM_DIGITS-1:0] w_anodes_show;

   scan_prescaler #(
      .DIV          (c_div),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_prescaler (
      .clk          (clk),
      .reset_n      (reset_n),
      .o_blank_done (w_blank_done),
      .o_dwell_done (w_dwell_done)
   );

   always_comb begin
      w_lit = digit_en[r_counter];
`ifdef LEADING_ZERO_SUPPRESS_EN
      // Judged on the latched frame so a digit never flickers mid-frame
      if (r_counter != '0 && upper_nibbles_zero(r_hex_frame, r_counter)) begin
         w_lit = 1'b0;
      end
`endif
      w_anodes_show            = ANODES_OFF;
      w_anodes_show[r_counter] = ~w_lit;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_BLANK;
         r_counter    <= '0;
         r_hex_frame  <= '0;
         r_anodes     <= ANODES_OFF;
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= 1'b0;
         case (r_state)
            S_BLANK: begin
               r_anodes <= ANODES_OFF;
               if (w_blank_done) begin
                  r_state  <= S_SHOW;
                  r_anodes <= w_anodes_show;
               end
            end
            S_SHOW: begin
               if (w_dwell_done) begin
                  r_state   <= S_BLANK;
                  r_anodes  <= ANODES_OFF;
                  r_counter <= r_counter + digit_idx_t'(1);
                  if (r_counter == digit_idx_t'(NUM_DIGITS - 1)) begin
                     r_hex_frame  <= hex_in;
                     r_frame_tick <= 1'b1;
                  end
               end else begin
                  r_anodes <= w_anodes_show;
               end
            end
            default: begin
               r_state  <= S_BLANK;
               r_anodes <= ANODES_OFF;
            end
         endcase
      end
   end

   assign hex_frame  = r_hex_frame;
   assign counter    = r_counter;
   assign anodes     = r_anodes;
   assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire
